// File: rtl/srlc_dline_pkg.sv
// Shared constants and sizing helpers for the cascaded-SRL delay line.
// Optional feature macro: SRLC_DLINE_SCAN_EN (see srlc_cascade_dline.sv).
package srlc_dline_pkg;

  // One SRLC32E primitive worth of storage.
  localparam int SEG_LEN = 32;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Bits of storage per channel.
  function automatic int depth_of(input int segments);
    return segments * SEG_LEN;
  endfunction

  // Tap address width per channel.
  function automatic int addr_w_of(input int segments);
    return clog2(depth_of(segments));
  endfunction

  // Fill counter must hold 0..CHANNELS*DEPTH inclusive.
  function automatic int fill_w_of(input int channels, input int segments);
    return clog2(channels * depth_of(segments) + 1);
  endfunction

endpackage

// File: rtl/srlc_cascade_dline_if.sv
// Control/data bundle for the delay line: shift enable, serial data,
// chaining selects, tap load and the per-channel observation outputs.
interface srlc_cascade_dline_if #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 7
);
  logic                         ce;
  logic [CHANNELS-1:0]          din;
  logic [CHANNELS-1:0]          chain_sel;
  logic                         tap_we;
  logic [CHANNELS*ADDR_W-1:0]   tap_addr;
  logic [CHANNELS-1:0]          dout;
  logic [CHANNELS-1:0]          dout_valid;
  logic [CHANNELS-1:0]          q_last;

  modport master (
    output ce, din, chain_sel, tap_we, tap_addr,
    input  dout, dout_valid, q_last
  );

  modport slave (
    input  ce, din, chain_sel, tap_we, tap_addr,
    output dout, dout_valid, q_last
  );
endinterface

// File: rtl/srlc_dline_chan.sv
// One delay channel: DEPTH bits of shift storage (SEGMENTS SRL32 segments
// cascaded end-to-start, so a flat shift register), a clamped tap register,
// the tap read mux and the registered, validity-masked output.
module srlc_dline_chan #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              d,
  input  logic              tap_we,
  input  logic [ADDR_W-1:0] tap_in,
  input  logic              valid_n,
  output logic [ADDR_W-1:0] tap,
  output logic              q_last,
  output logic              dout,
  output logic              dout_valid
);

  logic [DEPTH-1:0]  mem;
  logic [ADDR_W-1:0] tap_clamped;
  logic              q;

  // Storage has no reset, like the SRL primitive; stale bits are hidden by dout_valid.
  always_ff @(posedge clk)
    if (ce) mem <= {mem[DEPTH-2:0], d};

  // Taps past the end (only possible when DEPTH is not a power of two) pin to the last bit.
  always_comb begin
    tap_clamped = tap_in;
    if (int'(tap_in) > DEPTH - 1) tap_clamped = ADDR_W'(DEPTH - 1);
  end

  // Tap register; the new tap steers the read mux from the next edge on.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      tap <= '0;
    else if (tap_we) tap <= tap_clamped;

  assign q      = mem[tap];
  assign q_last = mem[DEPTH-1];

  // Output register re-samples every edge, regardless of ce.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= valid_n & q;
      dout_valid <= valid_n;
    end

endmodule

// File: rtl/srlc_cascade_dline.sv
// Multi-channel variable-tap delay line. Each channel is fed by its own din
// or, when chained, by the previous channel's last storage bit, so a run of
// chained channels behaves as one longer line.
// Optional feature macro: SRLC_DLINE_SCAN_EN adds scan_stb/scan_so and a
// capture/shift register over the dout vector.
module srlc_cascade_dline
  import srlc_dline_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEGMENTS = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SRLC_DLINE_SCAN_EN
  input  logic scan_stb,
  output logic scan_so,
`endif
  srlc_cascade_dline_if.slave bus
);

  localparam int DEPTH  = depth_of(SEGMENTS);
  localparam int ADDR_W = addr_w_of(SEGMENTS);
  localparam int FILL_W = fill_w_of(CHANNELS, SEGMENTS);
  localparam int RUN_W  = clog2(CHANNELS + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(CHANNELS * DEPTH);

  logic [CHANNELS-1:0]             d;
  logic [CHANNELS-1:0]             q_last;
  logic [CHANNELS-1:0]             dout;
  logic [CHANNELS-1:0]             dout_valid;
  logic [CHANNELS-1:0]             valid_n;
  logic [CHANNELS-1:0][ADDR_W-1:0] tap;
  logic [CHANNELS-1:0][RUN_W-1:0]  run;
  logic [FILL_W-1:0]               fill_cnt;

  // Counts shifts since reset, saturating once every channel could be full.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      fill_cnt <= '0;
    else if (bus.ce && fill_cnt != FILL_MAX)
      fill_cnt <= fill_cnt + FILL_W'(1);

  // Number of upstream channels feeding channel k through consecutive chain links.
  always_comb begin
    logic [RUN_W-1:0] acc;
    acc = '0;
    run = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (k == 0)                acc = '0;
      else if (bus.chain_sel[k]) acc = acc + RUN_W'(1);
      else                       acc = '0;
      run[k] = acc;
    end
  end

  // A tap is trustworthy once enough shifts have passed through it and every chained stage ahead.
  always_comb begin
    valid_n = '0;
    for (int k = 0; k < CHANNELS; k++)
      valid_n[k] = fill_cnt > (FILL_W'(tap[k]) + FILL_W'(run[k]) * FILL_W'(DEPTH));
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    if (k == 0) begin : g_head
      assign d[k] = bus.din[k];
    end else begin : g_link
      // Chain source is the pre-edge last bit of the neighbour, exactly like Q31->D.
      assign d[k] = bus.chain_sel[k] ? q_last[k-1] : bus.din[k];
    end

    srlc_dline_chan #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (bus.ce),
      .d          (d[k]),
      .tap_we     (bus.tap_we),
      .tap_in     (bus.tap_addr[k*ADDR_W +: ADDR_W]),
      .valid_n    (valid_n[k]),
      .tap        (tap[k]),
      .q_last     (q_last[k]),
      .dout       (dout[k]),
      .dout_valid (dout_valid[k])
    );
  end

  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.q_last     = q_last;

`ifdef SRLC_DLINE_SCAN_EN
  logic [CHANNELS-1:0] scan_reg;

  // Strobe snapshots dout; otherwise shift out MSB first with zero fill.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        scan_reg <= '0;
    else if (scan_stb) scan_reg <= dout;
    else               scan_reg <= scan_reg << 1;

  assign scan_so = scan_reg[CHANNELS-1];
`endif

endmodule

// File: tb/tb_srlc_cascade_dline.sv
// Scoreboard bench for srlc_cascade_dline (CHANNELS=4, SEGMENTS=4).
module tb_srlc_cascade_dline;

  localparam int CH    = 4;
  localparam int SEG   = 4;
  localparam int DEPTH = SEG * 32;
  localparam int AW    = 7;
  localparam int FMAX  = CH * DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  srlc_cascade_dline_if #(.CHANNELS(CH), .ADDR_W(AW)) bus ();

`ifdef SRLC_DLINE_SCAN_EN
  logic scan_stb;
  logic scan_so;
`endif

  srlc_cascade_dline #(.CHANNELS(CH), .SEGMENTS(SEG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SRLC_DLINE_SCAN_EN
    .scan_stb (scan_stb),
    .scan_so  (scan_so),
`endif
    .bus      (bus)
  );

  typedef struct packed {
    logic [CH-1:0] dout;
    logic [CH-1:0] dv;
  } exp_t;

  logic [DEPTH-1:0] m_mem [CH];
  int               m_fill;
  int               m_tap [CH];
  exp_t             sbq [$];
  bit               ql_known;
  int               total;
  int               bad;

  function automatic logic [CH*AW-1:0] taps(input int t0, input int t1, input int t2, input int t3);
    logic [CH*AW-1:0] r;
    r = {AW'(t3), AW'(t2), AW'(t1), AW'(t0)};
    return r;
  endfunction

  function automatic logic [CH-1:0] model_qlast();
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = m_mem[k][DEPTH-1];
    return r;
  endfunction

  // One clock: predict outputs from pre-edge model state, advance the model, then compare.
  task automatic tick();
    exp_t          e;
    exp_t          got;
    logic [CH-1:0] ql;
    logic [CH-1:0] d;
    int            run;
    ql  = model_qlast();
    run = 0;
    for (int k = 0; k < CH; k++) begin
      if (k > 0 && bus.chain_sel[k]) run++;
      else run = 0;
      e.dv[k]   = m_fill > m_tap[k] + DEPTH * run;
      e.dout[k] = e.dv[k] ? m_mem[k][m_tap[k]] : 1'b0;
    end
    sbq.push_back(e);
    if (bus.ce) begin
      for (int k = 0; k < CH; k++) begin
        if (k > 0 && bus.chain_sel[k]) d[k] = ql[k-1];
        else d[k] = bus.din[k];
        m_mem[k] = {m_mem[k][DEPTH-2:0], d[k]};
      end
      if (m_fill < FMAX) m_fill++;
    end
    if (bus.tap_we)
      for (int k = 0; k < CH; k++) m_tap[k] = int'(bus.tap_addr[k*AW +: AW]);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    total++;
    if (bus.dout !== got.dout) begin
      bad++;
      $display("FAIL sb_dout: got %b want %b at %0t", bus.dout, got.dout, $time);
    end
    total++;
    if (bus.dout_valid !== got.dv) begin
      bad++;
      $display("FAIL sb_valid: got %b want %b at %0t", bus.dout_valid, got.dv, $time);
    end
    if (ql_known) begin
      total++;
      if (bus.q_last !== model_qlast()) begin
        bad++;
        $display("FAIL sb_qlast: got %b want %b at %0t", bus.q_last, model_qlast(), $time);
      end
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.dout !== '0) begin
      bad++;
      $display("FAIL rst_dout: got %b want 0000", bus.dout);
    end
    total++;
    if (bus.dout_valid !== '0) begin
      bad++;
      $display("FAIL rst_valid: got %b want 0000", bus.dout_valid);
    end
    if (ql_known) begin
      total++;
      if (bus.q_last !== model_qlast()) begin
        bad++;
        $display("FAIL rst_retain: got %b want %b", bus.q_last, model_qlast());
      end
    end
    m_fill = 0;
    for (int k = 0; k < CH; k++) m_tap[k] = 0;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_taps(input logic [CH*AW-1:0] t);
    bus.ce = 1'b0; bus.tap_we = 1'b1; bus.tap_addr = t;
    tick();
    bus.tap_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.ce = 1'b0; bus.din = '0; bus.chain_sel = '0;
    tick();
    total++;
    if (bus.dout_valid !== '0) begin
      bad++;
      $display("FAIL reset_hold: got %b want 0000", bus.dout_valid);
    end
  endtask

  task automatic test_basic();
    bus.ce = 1'b1; bus.chain_sel = '0; bus.din = 4'b0001;
    tick();
    bus.din = '0;
    total++;
    if (bus.dout_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_v1: got %b want 0", bus.dout_valid[0]);
    end
    tick();
    total++;
    if (bus.dout[0] !== 1'b1 || bus.dout_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL basic_e2: got d=%b v=%b want d=1 v=1", bus.dout[0], bus.dout_valid[0]);
    end
    tick();
    total++;
    if (bus.dout[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_e3: got %b want 0", bus.dout[0]);
    end
    repeat (2) tick();
  endtask

  task automatic test_walk();
    load_taps(taps(0, 127, 0, 0));
    bus.ce = 1'b1; bus.din = 4'b0010;
    tick();
    bus.din = '0;
    for (int j = 1; j <= 129; j++) begin
      tick();
      if (j == 127) begin
        total++;
        if (bus.q_last[1] !== 1'b1) begin
          bad++;
          $display("FAIL walk_qlast: got %b want 1", bus.q_last[1]);
        end
      end
      if (j == 128 || j == 129) begin
        total++;
        if (bus.dout[1] !== (j == 128) || bus.dout_valid[1] !== 1'b1) begin
          bad++;
          $display("FAIL walk_dout j=%0d: got d=%b v=%b want d=%0d v=1", j, bus.dout[1], bus.dout_valid[1], j == 128);
        end
      end
    end
  endtask

  task automatic test_chain();
    do_reset();
    bus.chain_sel = 4'b0010;
    load_taps(taps(0, 5, 0, 0));
    bus.ce = 1'b1; bus.din = 4'b0001;
    tick();
    bus.din = '0;
    for (int j = 1; j <= 136; j++) begin
      tick();
      if (j >= 133 && j <= 135) begin
        total++;
        if (bus.dout[1] !== (j == 134) || bus.dout_valid[1] !== (j >= 134)) begin
          bad++;
          $display("FAIL chain j=%0d: got d=%b v=%b want d=%0d v=%0d", j, bus.dout[1], bus.dout_valid[1], j == 134, j >= 134);
        end
      end
    end
    bus.chain_sel = '0;
  endtask

  task automatic test_ce_toggle();
    load_taps(taps(3, 3, 3, 3));
    bus.ce = 1'b1; bus.din = 4'b0100;
    tick();
    bus.din = '0;
    for (int i = 1; i <= 12; i++) begin
      bus.ce = (i % 2 == 0);
      tick();
      if (i % 2 == 1) begin
        total++;
        if (int'(dut.fill_cnt) !== m_fill) begin
          bad++;
          $display("FAIL fill_hold: got %0d want %0d", dut.fill_cnt, m_fill);
        end
      end
      if (i >= 6 && i <= 9) begin
        total++;
        if (bus.dout[2] !== (i == 7 || i == 8)) begin
          bad++;
          $display("FAIL ce_delay i=%0d: got %b want %0d", i, bus.dout[2], i == 7 || i == 8);
        end
      end
    end
    // tap change while frozen, then tap load together with a shift
    bus.ce = 1'b0; bus.din = 4'b1111; bus.tap_we = 1'b1; bus.tap_addr = taps(0, 1, 0, 2);
    tick();
    bus.tap_we = 1'b0;
    tick();
    bus.ce = 1'b1; bus.tap_we = 1'b1; bus.tap_addr = taps(1, 0, 2, 0);
    tick();
    bus.tap_we = 1'b0; bus.din = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int pre;
    do_reset();
    load_taps(taps(10, 70, 30, 59));
    bus.ce = 1'b1;
    while (m_fill < 60) begin
      bus.din = CH'($urandom);
      tick();
    end
    total++;
    if (bus.dout_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_prevalid: got %b want 1", bus.dout_valid[0]);
    end
    do_reset();
    load_taps(taps(10, 70, 30, 59));
    bus.ce = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bus.din = CH'($urandom);
      pre = m_fill;
      tick();
      if (pre == 30 || pre == 31) begin
        total++;
        if (bus.dout_valid[2] !== (pre == 31)) begin
          bad++;
          $display("FAIL mid_refill fill=%0d: got %b want %0d", pre, bus.dout_valid[2], pre == 31);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.ce = ($urandom_range(0, 3) != 0);
      bus.din = CH'($urandom);
      if (i % 50 == 0) bus.chain_sel = CH'($urandom);
      bus.tap_we = ($urandom_range(0, 15) == 0);
      bus.tap_addr = (CH*AW)'({$urandom, $urandom});
      tick();
    end
    bus.tap_we = 1'b0;
  endtask

`ifdef SRLC_DLINE_SCAN_EN
  task automatic test_scan();
    logic [4:0] want;
    want = 5'b10100;
    bus.chain_sel = '0;
    load_taps(taps(0, 0, 0, 0));
    bus.ce = 1'b1; bus.din = 4'b1010;
    repeat (2) tick();
    bus.ce = 1'b0;
    total++;
    if (bus.dout !== 4'b1010) begin
      bad++;
      $display("FAIL scan_setup: got %b want 1010", bus.dout);
    end
    scan_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      scan_stb = 1'b0;
      total++;
      if (scan_so !== want[4-i]) begin
        bad++;
        $display("FAIL scan_so i=%0d: got %b want %b", i, scan_so, want[4-i]);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; ql_known = 1'b0; m_fill = 0;
    for (int k = 0; k < CH; k++) begin
      m_mem[k] = '0;
      m_tap[k] = 0;
    end
    bus.ce = 1'b0; bus.din = '0; bus.chain_sel = '0; bus.tap_we = 1'b0; bus.tap_addr = '0;
`ifdef SRLC_DLINE_SCAN_EN
    scan_stb = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // flush power-up storage so q_last is known everywhere
    bus.ce = 1'b1;
    repeat (DEPTH + 2) tick();
    ql_known = 1'b1;

    test_reset();
    test_basic();
    test_walk();
    test_chain();
    test_ce_toggle();
    test_reset_mid();
`ifdef SRLC_DLINE_SCAN_EN
    test_scan();
`endif
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
